uart_fw_sender: RTL and testbench

UART_FW_SENDER -- requirements
Module: uart_fw_sender

---
 rtl/uart_fw_sender.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_fw_sender.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fw_sender.sv
// Streams a firmware image over a memory-mapped UART as 131-byte packets
// (sequence byte, 128 payload bytes, CRC-16/MODBUS), with ACK/NAK and retry handling.
module uart_fw_sender #(
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [31:0] ACK_TIMEOUT = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] size_i,
    output logic        req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [3:0]  state_o
);
    localparam logic [31:0] ADDR_CTRL   = 32'h3000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h3000_0004;
    localparam logic [31:0] ADDR_BAUD   = 32'h3000_0008;
    localparam logic [31:0] ADDR_TX     = 32'h3000_000C;
    localparam logic [31:0] ADDR_RX     = 32'h3000_0010;

    typedef enum logic [3:0] {
        IDLE, INIT_CTRL, INIT_BAUD, PKT_START, LOAD_WORD, TX_POLL, TX_POLL2, TX_WRITE,
        CRC, RX_CLEAR, RX_POLL, RX_POLL2, RX_READ, RX_EVAL, DONE, ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [24:0] pkt_q, pkt_d;
    logic        hdr_q, hdr_d;
    logic [31:0] src_q, src_d;
    logic [31:0] size_q, size_d;
    logic [31:0] word_q, word_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] retry_q, retry_d;
    logic [7:0]  bidx_q, bidx_d;
    logic [15:0] crc_q, crc_d;
    logic        ld_q, ld_d;
    logic        tmo_hit_q, tmo_hit_d;

    logic [6:0]  pay_idx;
    logic [7:0]  hdr_byte;
    logic [7:0]  cur_byte;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Byte 128 maps to payload index 127 through the 7-bit wrap of bidx-1.
    always_comb begin
        pay_idx  = bidx_q[6:0] - 7'd1;
        hdr_byte = 8'h00;
        case (bidx_q)
            8'd61:   hdr_byte = size_q[31:24];
            8'd62:   hdr_byte = size_q[23:16];
            8'd63:   hdr_byte = size_q[15:8];
            8'd64:   hdr_byte = size_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
        if (bidx_q == 8'd0)
            cur_byte = seq_q;
        else if (bidx_q <= 8'd128)
            cur_byte = hdr_q ? hdr_byte : word_q[{pay_idx[1:0], 3'b000} +: 8];
        else if (bidx_q == 8'd129)
            cur_byte = crc_q[7:0];
        else
            cur_byte = crc_q[15:8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            seq_q     <= '0;
            pkt_q     <= '0;
            hdr_q     <= 1'b0;
            src_q     <= '0;
            size_q    <= '0;
            word_q    <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            bidx_q    <= '0;
            crc_q     <= '0;
            ld_q      <= 1'b0;
            tmo_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            pkt_q     <= pkt_d;
            hdr_q     <= hdr_d;
            src_q     <= src_d;
            size_q    <= size_d;
            word_q    <= word_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            bidx_q    <= bidx_d;
            crc_q     <= crc_d;
            ld_q      <= ld_d;
            tmo_hit_q <= tmo_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        pkt_d       = pkt_q;
        hdr_d       = hdr_q;
        src_d       = src_q;
        size_d      = size_q;
        word_d      = word_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        bidx_d      = bidx_q;
        crc_d       = crc_q;
        ld_d        = ld_q;
        tmo_hit_d   = tmo_hit_q;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        done_o      = 1'b0;
        err_o       = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                done_o = (state_q == DONE);
                err_o  = (state_q == ERR);
                if (state_q == DONE) state_d = IDLE;
                if (start_i) begin
                    src_d   = src_addr_i;
                    size_d  = size_i;
                    seq_d   = 8'h00;
                    hdr_d   = 1'b1;
                    pkt_d   = '0;
                    retry_d = '0;
                    state_d = INIT_CTRL;
                end
            end
            INIT_CTRL: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = ADDR_CTRL;
                mem_wdata_o = 32'h3;
                state_d     = INIT_BAUD;
            end
            INIT_BAUD: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = ADDR_BAUD;
                mem_wdata_o = 32'h1B8;
                state_d     = PKT_START;
            end
            PKT_START: begin
                bidx_d  = 8'd0;
                crc_d   = 16'hFFFF;
                state_d = TX_POLL;
            end
            LOAD_WORD: begin
                mem_addr_o = src_q + {pkt_q, 7'b0} + {25'b0, pay_idx[6:2], 2'b00};
                ld_d       = 1'b1;
                state_d    = TX_POLL;
            end
            TX_POLL: begin
                // Read data arriving now answers the LOAD_WORD address.
                if (ld_q) begin
                    word_d = mem_rdata_i;
                    ld_d   = 1'b0;
                end
                mem_addr_o = ADDR_STATUS;
                state_d    = TX_POLL2;
            end
            TX_POLL2: state_d = mem_rdata_i[0] ? TX_POLL : TX_WRITE;
            TX_WRITE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = ADDR_TX;
                mem_wdata_o = {24'h0, cur_byte};
                state_d     = CRC;
            end
            CRC: begin
                if (bidx_q >= 8'd1 && bidx_q <= 8'd128) crc_d = crc_step(crc_q, cur_byte);
                if (bidx_q == 8'd130) begin
                    state_d = RX_CLEAR;
                end else begin
                    bidx_d  = bidx_q + 8'd1;
                    state_d = (!hdr_q && bidx_q[1:0] == 2'b00 && bidx_q < 8'd128) ? LOAD_WORD : TX_POLL;
                end
            end
            RX_CLEAR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = ADDR_STATUS;
                mem_wdata_o = 32'h0;
                tmo_d       = '0;
                tmo_hit_d   = 1'b0;
                state_d     = RX_POLL;
            end
            RX_POLL: begin
                mem_addr_o = ADDR_STATUS;
                tmo_d      = tmo_q + 32'd1;
                state_d    = RX_POLL2;
            end
            RX_POLL2: begin
                tmo_d = tmo_q + 32'd1;
                if (mem_rdata_i[1]) begin
                    state_d = RX_READ;
                end else if ((tmo_q + 32'd1) >= ACK_TIMEOUT) begin
                    tmo_hit_d = 1'b1;
                    state_d   = RX_EVAL;
                end else begin
                    state_d = RX_POLL;
                end
            end
            RX_READ: begin
                mem_addr_o = ADDR_RX;
                state_d    = RX_EVAL;
            end
            RX_EVAL: begin
                if (!tmo_hit_q && mem_rdata_i[7:0] == 8'h06) begin
                    retry_d = '0;
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        pkt_d   = '0;
                        seq_d   = seq_q + 8'd1;
                        state_d = PKT_START;
                    end else if (pkt_q == size_q[31:7]) begin
                        state_d = DONE;
                    end else begin
                        pkt_d   = pkt_q + 25'd1;
                        seq_d   = seq_q + 8'd1;
                        state_d = PKT_START;
                    end
                end else if (retry_q >= MAX_RETRY) begin
                    state_d = ERR;
                end else begin
                    retry_d = retry_q + 32'd1;
                    state_d = PKT_START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign req_o   = busy_o;
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_fw_sender.sv
// Bench for uart_fw_sender: memory and UART response model, packets checked against
// a byte-level reference built from the packet format and CRC-16/MODBUS rules.
`timescale 1ns/1ps
module tb_uart_fw_sender;
    localparam int MAX_RETRY   = 3;
    localparam int ACK_TIMEOUT = 100;
    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_BAUD   = 32'h3000_0008;
    localparam logic [31:0] A_TX     = 32'h3000_000C;
    localparam logic [31:0] A_RX     = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] size_i;
    logic        req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [3:0]  state_o;

    uart_fw_sender #(.MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(32'(ACK_TIMEOUT))) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i), .size_i(size_i),
        .req_o(req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory image and UART model state
    logic [31:0]   mem [logic [31:0]];
    int            resp_plan[$];
    logic          rx_over = 1'b0;
    logic [7:0]    rx_val = 8'h00;
    int            tx_busy_cnt = 0;
    logic          last_rep_busy = 1'b0;
    logic [31:0]   rdata_pending = 32'h0;
    logic [7:0]    cur_bytes[$];
    logic [1047:0] pkts[$];
    int            first_tx_cyc[$];
    int            clear_cyc[$];
    logic [31:0]   w_addr[$];
    logic [31:0]   w_data[$];
    int cyc = 0;
    int tx_writes = 0, all_writes = 0, busy_violations = 0, busy_reads = 0;
    int done_pulses = 0, bad_writes = 0, len_bad = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [15:0] crc16(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) begin
            c = c ^ {8'h00, d[i]};
            for (int s = 0; s < 8; s++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [1047:0] ref_pkt(input logic [7:0] seq, input bit hdr,
                                              input logic [31:0] src, input logic [31:0] size,
                                              input int k);
        logic [7:0]    pay[$];
        logic [31:0]   w;
        logic [15:0]   c;
        logic [1047:0] p;
        for (int j = 0; j < 128; j++) pay.push_back(8'h00);
        if (hdr) begin
            pay[60] = size[31:24];
            pay[61] = size[23:16];
            pay[62] = size[15:8];
            pay[63] = size[7:0];
        end else begin
            for (int j = 0; j < 32; j++) begin
                w = mem_rd(src + 32'(128 * k) + 32'(4 * j));
                for (int m = 0; m < 4; m++) pay[4 * j + m] = w[8 * m +: 8];
            end
        end
        c = crc16(pay);
        p = '0;
        p[7:0] = seq;
        for (int j = 0; j < 128; j++) p[(j + 1) * 8 +: 8] = pay[j];
        p[129 * 8 +: 8] = c[7:0];
        p[130 * 8 +: 8] = c[15:8];
        return p;
    endfunction

    function automatic logic [7:0] pkt_byte(input int idx, input int b);
        logic [1047:0] p;
        if (idx >= pkts.size()) return 8'hxx;
        p = pkts[idx];
        return p[b * 8 +: 8];
    endfunction

    // Bus monitor and UART/memory responder; read data appears the cycle after the address.
    always @(negedge clk) begin
        logic [1047:0] p;
        int r;
        cyc++;
        if (!rst) begin
            cur_bytes.delete();
            rx_over       = 1'b0;
            rdata_pending = 32'h0;
            last_rep_busy = 1'b0;
        end else begin
            if (tx_busy_cnt > 0) tx_busy_cnt--;
            if (done_o) done_pulses++;
            if (mem_we_o) begin
                all_writes++;
                w_addr.push_back(mem_addr_o);
                w_data.push_back(mem_wdata_o);
                if (mem_addr_o == A_TX) begin
                    tx_writes++;
                    if (last_rep_busy) busy_violations++;
                    if (mem_wdata_o[31:8] != 24'h0) bad_writes++;
                    if (cur_bytes.size() == 0) first_tx_cyc.push_back(cyc);
                    cur_bytes.push_back(mem_wdata_o[7:0]);
                end else if (mem_addr_o == A_STATUS) begin
                    if (mem_wdata_o != 32'h0) bad_writes++;
                    if (cur_bytes.size() != 131) len_bad++;
                    p = '0;
                    foreach (cur_bytes[i]) if (i < 131) p[i * 8 +: 8] = cur_bytes[i];
                    pkts.push_back(p);
                    cur_bytes.delete();
                    clear_cyc.push_back(cyc);
                    r = (resp_plan.size() > 0) ? resp_plan.pop_front() : 6;
                    rx_over = (r >= 0);
                    rx_val  = 8'(r);
                end else if (mem_addr_o != A_CTRL && mem_addr_o != A_BAUD) begin
                    bad_writes++;
                end
            end else if (mem_addr_o == A_STATUS) begin
                rdata_pending = {30'h0, rx_over, tx_busy_cnt > 0};
                last_rep_busy = (tx_busy_cnt > 0);
                if (tx_busy_cnt > 0) busy_reads++;
            end else if (mem_addr_o == A_RX) begin
                rdata_pending = {24'h0, rx_val};
            end else begin
                rdata_pending = mem_rd(mem_addr_o);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata_i = rdata_pending;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pkt(input string tag, input int idx, input logic [1047:0] exp);
        logic [1047:0] obs;
        int b;
        checks++;
        obs = (idx < pkts.size()) ? pkts[idx] : 'x;
        b = 0;
        for (int i = 130; i >= 0; i--) if (obs[i * 8 +: 8] !== exp[i * 8 +: 8]) b = i;
        assert (idx < pkts.size() && obs === exp) else begin
            errors++;
            $error("FAIL %s pkt%0d byte%0d observed=%0h expected=%0h (have %0d pkts)",
                   tag, idx, b, obs[b * 8 +: 8], exp[b * 8 +: 8], pkts.size());
        end
    endtask

    task automatic clear_log();
        pkts.delete(); first_tx_cyc.delete(); clear_cyc.delete();
        w_addr.delete(); w_data.delete(); resp_plan.delete();
        tx_writes = 0; all_writes = 0; busy_violations = 0; busy_reads = 0;
        done_pulses = 0; bad_writes = 0; len_bad = 0;
    endtask

    task automatic fill_mem(input logic [31:0] src, input int words);
        for (int i = 0; i < words; i++) mem[src + 32'(4 * i)] = $urandom;
    endtask

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] size);
        @(posedge clk);
        #1;
        start_i = 1'b1; src_addr_i = src; size_i = size;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // outcome: 1 = done pulse seen, 2 = error flag seen, 0 = budget expired
    task automatic wait_end(input int budget, output int outcome);
        outcome = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) begin outcome = 1; break; end
            if (err_o)  begin outcome = 2; break; end
        end
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (tx_writes >= n) break;
            @(negedge clk);
        end
        check(tag, 64'(tx_writes >= n), 64'd1);
    endtask

    initial begin
        int outcome;
        int ctrl_cnt;
        int base_writes;
        int gap;
        logic [31:0] src;
        logic [7:0]  q9[$];
        logic [7:0]  pay_q[$];
        logic [15:0] exp_crc;

        rst = 1'b0; start_i = 1'b0; src_addr_i = 32'h0; size_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_req", req_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_state", state_o, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_we", mem_we_o, 0);

        // Full transfer, size 0x100 -> header + 3 data packets, all ACKed
        clear_log();
        src = {$urandom_range(32'h1000, 32'h3FFF), 2'b00};
        fill_mem(src, 96);
        start_xfer(src, 32'h100);
        repeat (30) @(negedge clk);
        start_xfer(32'h5000, 32'h1234_5678);
        wait_end(20000, outcome);
        check("t1_outcome", outcome, 1);
        check("t1_w0_addr", w_addr.size() > 0 ? w_addr[0] : 32'hx, A_CTRL);
        check("t1_w0_data", w_data.size() > 0 ? w_data[0] : 32'hx, 32'h3);
        check("t1_w1_addr", w_addr.size() > 1 ? w_addr[1] : 32'hx, A_BAUD);
        check("t1_w1_data", w_data.size() > 1 ? w_data[1] : 32'hx, 32'h1B8);
        ctrl_cnt = 0;
        foreach (w_addr[i]) if (w_addr[i] == A_CTRL) ctrl_cnt++;
        check("t1_ctrl_once", ctrl_cnt, 1);
        check("t1_npkts", pkts.size(), 4);
        check("t1_hdr_size", {pkt_byte(0, 61), pkt_byte(0, 62), pkt_byte(0, 63), pkt_byte(0, 64)},
              32'h0000_0100);
        check_pkt("t1_hdr", 0, ref_pkt(8'd0, 1'b1, src, 32'h100, 0));
        for (int k = 0; k < 3; k++) check_pkt("t1_data", k + 1, ref_pkt(8'(k + 1), 1'b0, src, 32'h100, k));
        check("t1_len", len_bad, 0);
        check("t1_bad_writes", bad_writes, 0);
        @(negedge clk);
        check("t1_done_pulses", done_pulses, 1);
        check("t1_idle_busy", busy_o, 0);

        // CRC on "123456789" followed by zeros, size 9 -> one data packet
        clear_log();
        q9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("ref_crc_9byte", crc16(q9), 16'h4B37);
        src = 32'h0000_2000;
        for (int i = 0; i < 32; i++) mem[src + 32'(4 * i)] = 32'h0;
        mem[src]      = 32'h3433_3231;
        mem[src + 4]  = 32'h3837_3635;
        mem[src + 8]  = 32'h0000_0039;
        pay_q = q9;
        for (int i = 9; i < 128; i++) pay_q.push_back(8'h00);
        exp_crc = crc16(pay_q);
        start_xfer(src, 32'd9);
        wait_end(20000, outcome);
        check("t2_outcome", outcome, 1);
        check("t2_npkts", pkts.size(), 2);
        check("t2_crc", {pkt_byte(1, 130), pkt_byte(1, 129)}, exp_crc);
        check_pkt("t2_data", 1, ref_pkt(8'd1, 1'b0, src, 32'd9, 0));

        // NAK on first data packet, then ACK; source wraps past 2^32
        clear_log();
        src = 32'hFFFF_FFC0;
        fill_mem(src, 64);
        resp_plan = '{6, 'h15};
        start_xfer(src, 32'h80);
        wait_end(20000, outcome);
        check("t3_outcome", outcome, 1);
        check("t3_npkts", pkts.size(), 4);
        check_pkt("t3_first", 1, ref_pkt(8'd1, 1'b0, src, 32'h80, 0));
        check_pkt("t3_resend", 2, ref_pkt(8'd1, 1'b0, src, 32'h80, 0));
        check_pkt("t3_next", 3, ref_pkt(8'd2, 1'b0, src, 32'h80, 1));

        // Four NAKs with MAX_RETRY=3 -> abort
        clear_log();
        resp_plan = '{6, 'h15, 'h15, 'h15, 'h15};
        start_xfer(src, 32'h80);
        wait_end(20000, outcome);
        check("t4_outcome", outcome, 2);
        check("t4_err", err_o, 1);
        check("t4_busy", busy_o, 0);
        check("t4_npkts", pkts.size(), 5);
        check("t4_tx_writes", tx_writes, 5 * 131);
        base_writes = all_writes;
        repeat (300) @(negedge clk);
        check("t4_no_writes", all_writes, base_writes);
        check("t4_err_held", err_o, 1);

        // Timeout then 0x41, both NAK; restarted from the error state
        clear_log();
        src = 32'h0000_3000;
        fill_mem(src, 32);
        resp_plan = '{6, -1, 'h41};
        start_xfer(src, 32'h0);
        @(negedge clk);
        check("t5_err_cleared", err_o, 0);
        check("t5_busy", busy_o, 1);
        wait_end(20000, outcome);
        check("t5_outcome", outcome, 1);
        check("t5_npkts", pkts.size(), 4);
        for (int i = 1; i < 4; i++) check_pkt("t5_data", i, ref_pkt(8'd1, 1'b0, src, 32'h0, 0));
        gap = (first_tx_cyc.size() > 2 && clear_cyc.size() > 1) ? first_tx_cyc[2] - clear_cyc[1] : -1;
        check("t5_timeout_gap", 64'(gap >= ACK_TIMEOUT && gap <= ACK_TIMEOUT + 10), 64'd1);
        gap = (first_tx_cyc.size() > 3 && clear_cyc.size() > 2) ? first_tx_cyc[3] - clear_cyc[2] : -1;
        check("t5_nak41_gap", 64'(gap > 0 && gap < ACK_TIMEOUT), 64'd1);

        // TX busy for 20 cycles, then reset mid-packet
        clear_log();
        src = {$urandom_range(32'h4000, 32'h7FFF), 2'b00};
        fill_mem(src, 96);
        start_xfer(src, 32'h100);
        wait_tx(10, 5000, "t6_reach_10");
        @(posedge clk);
        #2;
        tx_busy_cnt = 20;
        wait_tx(131 + 40, 10000, "t6_reach_mid");
        check("t6_busy_violations", busy_violations, 0);
        check("t6_busy_reported", 64'(busy_reads > 0), 64'd1);
        check_pkt("t6_hdr", 0, ref_pkt(8'd0, 1'b1, src, 32'h100, 0));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_req", req_o, 0);
        check("t6_rst_we", mem_we_o, 0);
        check("t6_rst_addr", mem_addr_o, 0);
        check("t6_rst_state", state_o, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("t6_post_rst_we", mem_we_o, 0);
        check("t6_post_rst_state", state_o, 0);
        base_writes = all_writes;
        repeat (50) @(negedge clk);
        check("t6_no_resume", all_writes, base_writes);
        check("t6_idle_busy", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
